dispatch_credit_queue: RTL and testbench

- Parametrised decoupling queue between decode and rename/dispatch.
- Accepts up to IN_W decoded uops per cycle and buffers them in a circular FIFO of DEPTH entries.
- Releases up to OUT_W uops per cycle, strictly in order, gated by per-bank RS credit counters and a ROB free count.
- Generalises the old single-cycle structural-hazard check to NUM_BANKS credit-tracked banks with buffering and flush.

---
 rtl/dispatch_credit_queue.sv | 181 ++++++++++++++++++
 tb/tb_dispatch_credit_queue.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_credit_queue.sv
// In-order decoupling queue between decode and rename/dispatch, gated by per-bank RS credits and ROB space.
// Define DISPATCH_BYPASS_EN to let an empty queue hand accepted decode lanes straight to dispatch in the same cycle.
module dispatch_credit_queue #(
  parameter int IN_W         = 3,
  parameter int OUT_W        = 3,
  parameter int DEPTH        = 8,
  parameter int NUM_BANKS    = 4,
  parameter int BANK_CREDITS = 16,
  parameter int UOP_W        = 64,
  parameter int BANK_W       = $clog2(NUM_BANKS),
  parameter int ROB_CNT_W    = 6
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic [IN_W-1:0]                        in_valid,
  input  logic [IN_W*UOP_W-1:0]                  in_uop,
  input  logic [IN_W*BANK_W-1:0]                 in_bank,
  output logic [$clog2(IN_W+1)-1:0]              in_accept_count,
  input  logic [ROB_CNT_W-1:0]                   rob_free,
  input  logic [NUM_BANKS*$clog2(OUT_W+1)-1:0]   credit_return,
  output logic [OUT_W-1:0]                       out_valid,
  output logic [OUT_W*UOP_W-1:0]                 out_uop,
  output logic [OUT_W*BANK_W-1:0]                out_bank,
  output logic [$clog2(DEPTH+1)-1:0]             occupancy,
  output logic                                   credit_err
);

  localparam int ACC_W = $clog2(IN_W + 1);
  localparam int RET_W = $clog2(OUT_W + 1);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CRD_W = $clog2(BANK_CREDITS + 1);
  localparam int LANES = (IN_W > OUT_W) ? IN_W : OUT_W;

  typedef struct packed {
    logic [BANK_W-1:0] bank;
    logic [UOP_W-1:0]  uop;
  } entry_t;

  entry_t           mem_q    [DEPTH];
  entry_t           mem_d    [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CRD_W-1:0] credit_q [NUM_BANKS];
  logic [CRD_W-1:0] credit_d [NUM_BANKS];
  logic             err_q, err_d;

  entry_t           in_entry [LANES];
  entry_t           cand     [OUT_W];
  logic [OUT_W-1:0] cand_ok;
  logic             bypass_act;
  int               valid_prefix;
  int               accept_n;
  int               disp_n;
  int               byp_n;
  int               wr_n;
  int               credit_sum;
  int               bank_used [NUM_BANKS];

  // Decode lanes unpacked into entries; lanes past IN_W exist only so the walk can index uniformly.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      in_entry[i] = '0;
      if (i < IN_W) begin
        in_entry[i].uop  = in_uop[i*UOP_W +: UOP_W];
        in_entry[i].bank = in_bank[i*BANK_W +: BANK_W];
      end
    end
  end

  // Free space is judged on start-of-cycle occupancy; same-cycle dequeues do not make room.
  always_comb begin
    valid_prefix = 0;
    for (int i = 0; i < IN_W; i++) begin
      if (in_valid[i] && valid_prefix == i) valid_prefix = valid_prefix + 1;
    end
    accept_n = DEPTH - int'(occ_q);
    if (valid_prefix < accept_n) accept_n = valid_prefix;
    if (flush || !reset) accept_n = 0;
    in_accept_count = ACC_W'(accept_n);
  end

`ifdef DISPATCH_BYPASS_EN
  assign bypass_act = (occ_q == '0) && !flush;
`else
  assign bypass_act = 1'b0;
`endif

  // Dispatch walk: a lane is granted only if every older lane was, which keeps issue strictly in order.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional write, so no latch is inferred.
    out_valid = '0;
    out_uop   = '0;
    out_bank  = '0;
    disp_n    = 0;
    for (int b = 0; b < NUM_BANKS; b++) bank_used[b] = 0;

    for (int k = 0; k < OUT_W; k++) begin
      if (bypass_act) begin
        cand[k]    = in_entry[k];
        cand_ok[k] = (k < accept_n);
      end else begin
        cand[k]    = mem_q[head_q + PTR_W'(k)];
        cand_ok[k] = (k < int'(occ_q));
      end
    end

    for (int k = 0; k < OUT_W; k++) begin
      if (disp_n == k && reset && !flush && cand_ok[k] && k < int'(rob_free) &&
          bank_used[cand[k].bank] < int'(credit_q[cand[k].bank])) begin
        out_valid[k]                   = 1'b1;
        out_uop[k*UOP_W +: UOP_W]      = cand[k].uop;
        out_bank[k*BANK_W +: BANK_W]   = cand[k].bank;
        bank_used[cand[k].bank]        = bank_used[cand[k].bank] + 1;
        disp_n                         = disp_n + 1;
      end
    end
  end

  // Bypassed lanes never touch storage; the remaining accepted lanes land at tail in lane order.
  always_comb begin
    byp_n      = bypass_act ? disp_n : 0;
    wr_n       = accept_n - byp_n;
    mem_d      = mem_q;
    credit_sum = 0;
    for (int i = 0; i < IN_W; i++) begin
      if (i >= byp_n && i < accept_n) mem_d[tail_q + PTR_W'(i - byp_n)] = in_entry[i];
    end
    head_d = head_q + PTR_W'(disp_n - byp_n);
    tail_d = tail_q + PTR_W'(wr_n);
    occ_d  = OCC_W'(int'(occ_q) + accept_n - disp_n);
    err_d  = err_q;

    // Returned credits only land in the register, so they are usable from the next cycle on.
    for (int b = 0; b < NUM_BANKS; b++) begin
      credit_sum = int'(credit_q[b]) - bank_used[b] + int'(credit_return[b*RET_W +: RET_W]);
      if (credit_sum > BANK_CREDITS) begin
        credit_d[b] = CRD_W'(BANK_CREDITS);
        err_d       = 1'b1;
      end else begin
        credit_d[b] = CRD_W'(credit_sum);
      end
    end

    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
      err_d  = err_q;
      for (int b = 0; b < NUM_BANKS; b++) credit_d[b] = CRD_W'(BANK_CREDITS);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      err_q  <= 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) credit_q[b] <= CRD_W'(BANK_CREDITS);
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      err_q  <= err_d;
      for (int b = 0; b < NUM_BANKS; b++) credit_q[b] <= credit_d[b];
    end
  end

  // NOTE: payload storage is not reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign occupancy  = occ_q;
  assign credit_err = err_q;

endmodule

// File: tb/tb_dispatch_credit_queue.sv
// Directed bench for dispatch_credit_queue: a queue-level model checked every cycle plus hand-computed pins.
// Honours DISPATCH_BYPASS_EN the same way the design does.
module tb_dispatch_credit_queue;

  localparam int DEPTH   = 8;
  localparam int OUT_W   = 3;
  localparam int IN_W    = 3;
  localparam int NB      = 4;
  localparam int CREDITS = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         flush;
  logic [2:0]   in_valid;
  logic [191:0] in_uop;
  logic [5:0]   in_bank;
  logic [1:0]   in_accept_count;
  logic [5:0]   rob_free;
  logic [7:0]   credit_return;
  logic [2:0]   out_valid;
  logic [191:0] out_uop;
  logic [5:0]   out_bank;
  logic [3:0]   occupancy;
  logic         credit_err;

  dispatch_credit_queue dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_uop(in_uop), .in_bank(in_bank),
    .in_accept_count(in_accept_count), .rob_free(rob_free),
    .credit_return(credit_return), .out_valid(out_valid),
    .out_uop(out_uop), .out_bank(out_bank),
    .occupancy(occupancy), .credit_err(credit_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] uop;
    logic [1:0]  bank;
  } item_t;

  item_t       mq[$];
  item_t       acc_list[$];
  item_t       view[$];
  item_t       it;
  int          cr [NB];
  bit          merr;
  bit          have_pred;
  int          p_ng;
  int          p_used [NB];
  logic        p_flush;
  logic [7:0]  p_ret;
  int          vp, space, acc, ng, nval;
  int          tests = 0;
  int          fails = 0;
  int          uid = 0;
  logic [63:0] first_uop;
  logic [1:0]  fill_exp [4] = '{2'd3, 2'd3, 2'd2, 2'd0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [2:0] v, input logic [1:0] b0, input logic [1:0] b1,
                        input logic [1:0] b2, input logic [5:0] rob, input logic [7:0] ret,
                        input logic fl);
    in_valid = v;
    in_bank  = {b2, b1, b0};
    for (int i = 0; i < IN_W; i++) begin
      in_uop[64*i +: 64] = 64'hC0DE_0000_0000_0000 + 64'(uid);
      uid++;
    end
    rob_free      = rob;
    credit_return = ret;
    flush         = fl;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    set_in(3'b000, 2'd0, 2'd0, 2'd0, 6'd10, 8'h00, 1'b0);
  endtask

  task automatic model_sync();
    @(negedge clock);
    #1;
  endtask

  // Model: a plain FIFO of uops plus an integer credit count per bank.
  always @(negedge clock) begin
    if (!reset) begin
      mq.delete();
      for (int b = 0; b < NB; b++) cr[b] = CREDITS;
      merr      = 1'b0;
      have_pred = 1'b0;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_accept", 64'(in_accept_count), 64'd0);
      check("reset_occupancy", 64'(occupancy), 64'd0);
      check("reset_credit_err", 64'(credit_err), 64'd0);
    end else begin
      if (have_pred) begin
        if (p_flush) begin
          mq.delete();
          for (int b = 0; b < NB; b++) cr[b] = CREDITS;
        end else begin
          foreach (acc_list[i]) mq.push_back(acc_list[i]);
          repeat (p_ng) void'(mq.pop_front());
          for (int b = 0; b < NB; b++) begin
            nval = cr[b] - p_used[b] + int'(p_ret[2*b +: 2]);
            if (nval > CREDITS) begin
              nval = CREDITS;
              merr = 1'b1;
            end
            cr[b] = nval;
          end
        end
      end

      vp = 0;
      for (int i = 0; i < IN_W; i++) if (in_valid[i] && vp == i) vp++;
      space = DEPTH - mq.size();
      acc   = (vp < space) ? vp : space;
      if (flush) acc = 0;
      acc_list.delete();
      for (int i = 0; i < acc; i++) begin
        it.uop  = in_uop[64*i +: 64];
        it.bank = in_bank[2*i +: 2];
        acc_list.push_back(it);
      end
      view = mq;
`ifdef DISPATCH_BYPASS_EN
      if (mq.size() == 0 && !flush) view = acc_list;
`endif
      for (int b = 0; b < NB; b++) p_used[b] = 0;
      ng = 0;
      if (!flush) begin
        for (int k = 0; k < OUT_W; k++) begin
          if (k >= view.size() || k >= int'(rob_free) ||
              p_used[view[k].bank] >= cr[view[k].bank]) break;
          p_used[view[k].bank]++;
          ng++;
        end
      end

      check("out_valid", 64'(out_valid), 64'((1 << ng) - 1));
      check("accept_count", 64'(in_accept_count), 64'(acc));
      check("occupancy", 64'(occupancy), 64'(mq.size()));
      check("credit_err", 64'(credit_err), 64'(merr));
      for (int k = 0; k < ng; k++) begin
        check("out_uop", out_uop[64*k +: 64], view[k].uop);
        check("out_bank", 64'(out_bank[2*k +: 2]), 64'(view[k].bank));
      end

      p_ng      = ng;
      p_flush   = flush;
      p_ret     = credit_return;
      have_pred = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before 100000");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset = 1'b0;
    set_in(3'b111, 2'd0, 2'd1, 2'd0, 6'd10, 8'h00, 1'b0);
    #2;
    check("lit_reset_accept", 64'(in_accept_count), 64'd0);
    check("lit_reset_out_valid", 64'(out_valid), 64'd0);
    repeat (2) @(posedge clock);
    #1;

    // Three lanes to banks {0,1,0}
    reset = 1'b1;
    set_in(3'b111, 2'd0, 2'd1, 2'd0, 6'd10, 8'h00, 1'b0);
    #1;
    check("lit_s1_accept", 64'(in_accept_count), 64'd3);
`ifdef DISPATCH_BYPASS_EN
    check("lit_s1_bypass_valid", 64'(out_valid), 64'h7);
`else
    check("lit_s1_no_bypass_valid", 64'(out_valid), 64'h0);
`endif
    tick();
    idle();
    #1;
`ifdef DISPATCH_BYPASS_EN
    check("lit_s1_occ_bypass", 64'(occupancy), 64'd0);
`else
    check("lit_s1_occ", 64'(occupancy), 64'd3);
    check("lit_s1_dispatch", 64'(out_valid), 64'h7);
`endif
    tick();
    idle();
    #1;
    check("lit_s1_drained", 64'(occupancy), 64'd0);
    model_sync();
    check("lit_model_cr0", 64'(cr[0]), 64'd14);
    check("lit_model_cr1", 64'(cr[1]), 64'd15);
    check("lit_model_cr2", 64'(cr[2]), 64'd16);
    check("lit_model_cr3", 64'(cr[3]), 64'd16);
    tick();

    // Drain bank 2 to zero credits, leaving [bank2, bank0] queued
    repeat (5) begin
      set_in(3'b111, 2'd2, 2'd2, 2'd2, 6'd10, 8'h00, 1'b0);
      tick();
    end
    set_in(3'b111, 2'd2, 2'd2, 2'd0, 6'd10, 8'h00, 1'b0);
    tick();
    idle();
    tick();
    idle();
    #1;
    check("lit_s2_blocked", 64'(out_valid), 64'h0);
    check("lit_s2_occ", 64'(occupancy), 64'd2);
    tick();
    set_in(3'b000, 2'd0, 2'd0, 2'd0, 6'd10, 8'h10, 1'b0);
    #1;
    check("lit_s2_ret_same_cycle", 64'(out_valid), 64'h0);
    tick();
    idle();
    #1;
    check("lit_s2_ret_next_cycle", 64'(out_valid), 64'h3);
    tick();

    // Fill to full behind a zero-credit bank, then release
    for (int c = 0; c < 4; c++) begin
      set_in(3'b111, 2'd2, 2'd2, 2'd2, 6'd10, 8'h00, 1'b0);
      if (c == 0) first_uop = in_uop[63:0];
      #1;
      check("lit_s3_fill_accept", 64'(in_accept_count), 64'(fill_exp[c]));
      tick();
    end
    set_in(3'b000, 2'd0, 2'd0, 2'd0, 6'd10, 8'h30, 1'b0);
    #1;
    check("lit_s3_full", 64'(occupancy), 64'd8);
    check("lit_s3_still_blocked", 64'(out_valid), 64'h0);
    tick();
    set_in(3'b111, 2'd1, 2'd1, 2'd1, 6'd10, 8'h30, 1'b0);
    #1;
    check("lit_s3_release", 64'(out_valid), 64'h7);
    check("lit_s3_fifo_head", out_uop[63:0], first_uop);
    check("lit_s3_full_accept", 64'(in_accept_count), 64'd0);
    tick();
    set_in(3'b000, 2'd0, 2'd0, 2'd0, 6'd10, 8'h30, 1'b0);
    tick();
    repeat (3) begin
      idle();
      tick();
    end

    // Prefix rule and ROB limit
    set_in(3'b111, 2'd1, 2'd1, 2'd1, 6'd0, 8'h00, 1'b0);
    #1;
    check("lit_s4_accept_rob0", 64'(in_accept_count), 64'd3);
    check("lit_s4_rob0_valid", 64'(out_valid), 64'h0);
    tick();
    set_in(3'b101, 2'd1, 2'd1, 2'd1, 6'd1, 8'h00, 1'b0);
    #1;
    check("lit_s4_prefix_accept", 64'(in_accept_count), 64'd1);
    check("lit_s4_rob1_valid", 64'(out_valid), 64'h1);
    tick();
    repeat (3) begin
      idle();
      tick();
    end

    // Reach credits {3,16,9,0}, hold five entries, then flush
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (4) begin
      set_in(3'b111, 2'd0, 2'd0, 2'd0, 6'd10, 8'h00, 1'b0);
      tick();
    end
    set_in(3'b111, 2'd0, 2'd2, 2'd2, 6'd10, 8'h00, 1'b0);
    tick();
    set_in(3'b111, 2'd2, 2'd2, 2'd2, 6'd10, 8'h00, 1'b0);
    tick();
    set_in(3'b111, 2'd2, 2'd2, 2'd3, 6'd10, 8'h00, 1'b0);
    tick();
    repeat (5) begin
      set_in(3'b111, 2'd3, 2'd3, 2'd3, 6'd10, 8'h00, 1'b0);
      tick();
    end
    repeat (2) begin
      idle();
      tick();
    end
    idle();
    model_sync();
    check("lit_s5_cr0", 64'(cr[0]), 64'd3);
    check("lit_s5_cr1", 64'(cr[1]), 64'd16);
    check("lit_s5_cr2", 64'(cr[2]), 64'd9);
    check("lit_s5_cr3", 64'(cr[3]), 64'd0);
    tick();
    set_in(3'b111, 2'd1, 2'd1, 2'd1, 6'd0, 8'h00, 1'b0);
    tick();
    set_in(3'b011, 2'd1, 2'd1, 2'd1, 6'd0, 8'h00, 1'b0);
    tick();
    set_in(3'b111, 2'd1, 2'd1, 2'd1, 6'd10, 8'h01, 1'b1);
    #1;
    check("lit_s5_pre_flush_occ", 64'(occupancy), 64'd5);
    check("lit_s5_flush_accept", 64'(in_accept_count), 64'd0);
    check("lit_s5_flush_valid", 64'(out_valid), 64'h0);
    tick();
    idle();
    #1;
    check("lit_s5_post_flush_occ", 64'(occupancy), 64'd0);
    check("lit_s5_post_flush_err", 64'(credit_err), 64'd0);
    model_sync();
    for (int b = 0; b < NB; b++) check("lit_s5_flush_credit", 64'(cr[b]), 64'd16);
    tick();
    set_in(3'b000, 2'd0, 2'd0, 2'd0, 6'd10, 8'h40, 1'b0);
    tick();
    idle();
    #1;
    check("lit_s5_err_set", 64'(credit_err), 64'd1);
    set_in(3'b000, 2'd0, 2'd0, 2'd0, 6'd10, 8'h00, 1'b1);
    tick();
    idle();
    #1;
    check("lit_s5_err_sticky", 64'(credit_err), 64'd1);
    tick();
    set_in(3'b111, 2'd3, 2'd3, 2'd3, 6'd10, 8'h00, 1'b0);
    tick();
    repeat (2) begin
      idle();
      tick();
    end

    // Reset clears the sticky error and masks outputs
    reset = 1'b0;
    set_in(3'b111, 2'd0, 2'd0, 2'd0, 6'd10, 8'h00, 1'b0);
    #1;
    check("lit_final_reset_valid", 64'(out_valid), 64'h0);
    check("lit_final_reset_accept", 64'(in_accept_count), 64'd0);
    check("lit_final_reset_occ", 64'(occupancy), 64'd0);
    check("lit_final_reset_err", 64'(credit_err), 64'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
